// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: emits the index of each set bit of an accepted vector, one per handshake, in priority order.
// The first index is valid the cycle after accept. dout/dout_last hold under stall, and din is only taken in IDLE.
module encoder_8x3_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic [7:0] din,
    output logic       din_ready,
    output logic [2:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_last,
    output logic       err_empty,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pending;
    logic [7:0] w_pending_nxt;
    logic [2:0] r_dout;
    logic [2:0] w_dout_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic [7:0] w_remain;
    logic       w_accept;
    logic       w_handshake;

    // Later loop iterations overwrite earlier ones, so the scan order decides which bit wins.
    function automatic logic [2:0] f_sel(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (LSB_FIRST) begin
                if (v[7-i]) idx = 3'(7 - i);
            end else begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic f_single(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

    assign din_ready   = (r_state == ST_IDLE);
    assign dout_valid  = (r_state == ST_EMIT);
    assign busy        = (r_state == ST_EMIT);
    assign dout        = r_dout;
    assign dout_last   = r_last;
    assign err_empty   = r_err;

    assign w_accept    = din_valid && din_ready;
    assign w_handshake = dout_valid && dout_ready;
    // r_dout always names the selected bit of r_pending, so it doubles as the clear mask.
    assign w_remain    = r_pending & ~(8'h01 << r_dout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 8'h00;
            r_dout    <= 3'd0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_dout    <= w_dout_nxt;
            r_last    <= w_last_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_dout_nxt    = r_dout;
        w_last_nxt    = r_last;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (din != 8'h00) begin
                        w_state_nxt   = ST_EMIT;
                        w_pending_nxt = din;
                        w_dout_nxt    = f_sel(din);
                        w_last_nxt    = f_single(din);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (w_handshake) begin
                    if (r_last) begin
                        w_state_nxt   = ST_IDLE;
                        w_pending_nxt = 8'h00;
                        w_dout_nxt    = 3'd0;
                        w_last_nxt    = 1'b0;
                    end else begin
                        w_pending_nxt = w_remain;
                        w_dout_nxt    = f_sel(w_remain);
                        w_last_nxt    = f_single(w_remain);
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = 8'h00;
                w_dout_nxt    = 3'd0;
                w_last_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Directed bench driving an LSB-first and an MSB-first encoder side by side against a queue-based scoreboard.
module tb_encoder_8x3_seq;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dout_ready = 1'b0;

    logic       l_din_ready, l_dout_valid, l_dout_last, l_err_empty, l_busy;
    logic [2:0] l_dout;
    logic       m_din_ready, m_dout_valid, m_dout_last, m_err_empty, m_busy;
    logic [2:0] m_dout;

    exp_t q_l[$];
    exp_t q_m[$];
    logic exp_err = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    encoder_8x3_seq #(.LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(l_din_ready),
        .dout(l_dout), .dout_valid(l_dout_valid), .dout_ready(dout_ready),
        .dout_last(l_dout_last), .err_empty(l_err_empty), .busy(l_busy)
    );

    encoder_8x3_seq #(.LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(m_din_ready),
        .dout(m_dout), .dout_valid(m_dout_valid), .dout_ready(dout_ready),
        .dout_last(m_dout_last), .err_empty(m_err_empty), .busy(m_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected index order is built independently for each emit direction.
    task automatic push_vec(input logic [7:0] v);
        int n;
        int seen;
        exp_t e;
        n = $countones(v);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                seen++;
                e.idx = 3'(i);
                e.last = (seen == n);
                q_l.push_back(e);
            end
        end
        seen = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                seen++;
                e.idx = 3'(i);
                e.last = (seen == n);
                q_m.push_back(e);
            end
        end
    endtask

    task automatic check_one(input int id, input logic v, input logic rdy, input logic bsy,
                             input logic lst, input logic er, input logic [2:0] d);
        string nm;
        int sz;
        exp_t e;
        nm = (id == 0) ? "lsb" : "msb";
        sz = (id == 0) ? q_l.size() : q_m.size();
        chk({nm, "_dout_valid"}, 8'(v), 8'(sz != 0));
        chk({nm, "_din_ready"}, 8'(rdy), 8'(sz == 0));
        chk({nm, "_busy"}, 8'(bsy), 8'(sz != 0));
        chk({nm, "_err_empty"}, 8'(er), 8'(exp_err));
        if (v && dout_ready && sz != 0) begin
            e = (id == 0) ? q_l.pop_front() : q_m.pop_front();
            chk({nm, "_dout"}, 8'(d), 8'(e.idx));
            chk({nm, "_dout_last"}, 8'(lst), 8'(e.last));
        end else if (sz == 0) begin
            chk({nm, "_dout_idle"}, 8'(d), 8'h00);
            chk({nm, "_last_idle"}, 8'(lst), 8'h00);
        end
    endtask

    task automatic tick();
        logic idle;
        logic nxt_err;
        @(negedge clk);
        idle = (q_l.size() == 0) && !rst;
        check_one(0, l_dout_valid, l_din_ready, l_busy, l_dout_last, l_err_empty, l_dout);
        check_one(1, m_dout_valid, m_din_ready, m_busy, m_dout_last, m_err_empty, m_dout);
        nxt_err = din_valid && idle && (din == 8'h00);
        if (din_valid && idle && din != 8'h00) push_vec(din);
        exp_err = nxt_err;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_lsb_dout", 8'(l_dout), 8'h00);
        chk("rst_lsb_valid", 8'(l_dout_valid), 8'h00);
        chk("rst_lsb_last", 8'(l_dout_last), 8'h00);
        chk("rst_lsb_err", 8'(l_err_empty), 8'h00);
        chk("rst_lsb_busy", 8'(l_busy), 8'h00);
        chk("rst_lsb_ready", 8'(l_din_ready), 8'h01);
        chk("rst_msb_dout", 8'(m_dout), 8'h00);
        chk("rst_msb_valid", 8'(m_dout_valid), 8'h00);
        chk("rst_msb_busy", 8'(m_busy), 8'h00);
        chk("rst_msb_ready", 8'(m_din_ready), 8'h01);
    endtask

    initial begin
        #2;
        chk_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) tick();

        // single one-hot vector
        dout_ready = 1'b1;
        din = 8'b0000_1000;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (3) tick();

        // multi-hot: 0,2,5,7 (lsb) and 7,5,2,0 (msb)
        din = 8'b1010_0101;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (6) tick();

        // stall, with a competing vector offered during EMIT
        dout_ready = 1'b0;
        din = 8'b0100_0010;
        din_valid = 1'b1;
        tick();
        din = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_lsb_dout", 8'(l_dout), 8'h01);
            chk("stall_msb_dout", 8'(m_dout), 8'h06);
            chk("stall_lsb_ready", 8'(l_din_ready), 8'h00);
        end
        din_valid = 1'b0;
        dout_ready = 1'b1;
        repeat (4) tick();

        // all-zero vector
        din = 8'h00;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (3) tick();

        // reset in the middle of a full vector
        din = 8'hFF;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        q_l.delete();
        q_m.delete();
        exp_err = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_8x3_seq.md
Name: encoder_8x3_seq

Overview:
- Sequential 8-to-3 encoder; the inverse of the 3x8 decoder/demux path.
- Accepts an 8-bit request vector (one-hot or multi-hot) and emits the 3-bit index of each set bit, one per handshake, in priority order.
- Sits between request sources (interrupt/event lines) and any consumer that needs binary indices, e.g. a downstream 3x8 decoder.

Parameters:
- LSB_FIRST, 1, emit order: 1 = lowest set bit first; 0 = highest set bit first.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- din_valid  input  1  request vector valid.
- din  input  8  request vector.
- din_ready  output  1  block can accept a vector (high only in IDLE).
- dout  output  3  index of the currently selected set bit.
- dout_valid  output  1  dout holds a valid index.
- dout_ready  input  1  consumer accepts dout this cycle.
- dout_last  output  1  current index is the final one of the vector.
- err_empty  output  1  one-cycle pulse when an all-zero vector is accepted.
- busy  output  1  high in EMIT.

Behaviour:
- Clock/reset: single clock clk; rst asynchronous, active-high. While rst is high the block forces state IDLE, pending=8'h00, dout=3'd0, dout_valid=0, dout_last=0, err_empty=0, busy=0, din_ready=1.
- Internal: pending[7:0] register; states IDLE and EMIT.
- IDLE:
  - din_ready=1, dout_valid=0.
  - Accept occurs on din_valid & din_ready at a clock edge.
  - Accept with din != 0: pending<=din, state<=EMIT. After that edge, dout_valid=1 and dout=index of the priority bit of din. dout_last=1 iff din has exactly one set bit.
  - Accept with din == 0: stay IDLE, no dout_valid, err_empty=1 for exactly the following cycle.
  - No accept: all outputs hold.
- EMIT:
  - din_ready=0, busy=1, dout_valid=1.
  - Selected bit: lowest set bit of pending if LSB_FIRST=1, else highest.
  - dout/dout_last are registered and must stay stable while dout_valid & !dout_ready (no change under stall).
  - Handshake (dout_valid & dout_ready at an edge), not last: clear the selected bit in pending. Next cycle dout = next priority index; dout_last is recomputed (1 iff exactly one bit remains).
  - Handshake on dout_last=1: pending<=0, state<=IDLE. After that edge, dout_valid=0, dout_last=0, busy=0, din_ready=1.
- Throughput:
  - With dout_ready held high, one index per cycle.
  - A vector with k set bits occupies k cycles in EMIT plus ≥1 IDLE cycle; accept and last handshake never occur in the same cycle.
- din is ignored while in EMIT, even if din_valid=1.
- dout after the final handshake returns to 3'd0.
- rst asserted mid-EMIT: immediate return to reset values and pending cleared; the interrupted vector is discarded and no further indices are emitted.

Test Plan:
- Reset, then idle with din_valid=0 -> din_ready=1, dout_valid=0, dout=0, err_empty=0, busy=0.
- LSB_FIRST=1, din=8'b0000_1000 accepted, dout_ready=1 -> one beat: dout=3, dout_last=1; din_ready=1 the cycle after.
- LSB_FIRST=1, din=8'b1010_0101, dout_ready=1 -> dout sequence 0,2,5,7 on consecutive cycles; dout_last only on 7.
- LSB_FIRST=0, din=8'b1010_0101 -> dout sequence 7,5,2,0.
- Stall: din=8'b0100_0010, dout_ready low for 3 cycles -> dout=1 held stable for 3 cycles; then 1,6 emitted. A new din presented during EMIT is ignored (din_ready=0).
- din=8'h00 accepted -> err_empty pulses for 1 cycle, no dout_valid. Then din=8'hFF with rst asserted after 2 handshakes (indices 0,1 seen) -> all outputs zero immediately; after release, din_ready=1 and no further indices.
